// File: rtl/key_entry_buffer.sv
// Key entry buffer: turns held key codes into single press events and keeps a
// 4-digit shift-entry buffer with backspace, clear, enter and an idle auto-clear.
module key_entry_buffer #(
  parameter int TIMEOUT_CYC = 250000000,
  parameter int MAX_DIGITS  = 4
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  output logic [15:0] entry,
  output logic [3:0]  digit_en,
  output logic [2:0]  count,
  output logic [15:0] value_out,
  output logic        done,
  output logic        overflow,
  output logic        timeout,
  output logic [7:0]  tries
);

  localparam logic [27:0] TIMER_LAST = 28'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  COUNT_MAX  = 3'(MAX_DIGITS);

  localparam logic [3:0] KEY_BACK  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  code_r;
  logic [27:0] timer;

  logic        capture;
  logic        exec_en;
  logic        timer_run;
  logic        timer_hit;
  logic        is_digit;

  // Handshake: key_valid is a level; one press is taken per high period, and
  // the FSM must see key_valid low before another press can be captured.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state <= WAIT_REL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    exec_en   = 1'b0;
    timer_run = 1'b0;
    timer_hit = 1'b0;
    case (state)
      IDLE: begin
        // A press on the expiry edge wins over the timeout.
        if (key_valid) begin
          state_nx = EXEC;
          capture  = 1'b1;
        end else if (count != 3'd0) begin
          timer_run = 1'b1;
          timer_hit = (timer == TIMER_LAST);
        end
      end
      EXEC: begin
        state_nx = WAIT_REL;
        exec_en  = 1'b1;
      end
      WAIT_REL: begin
        if (!key_valid) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = WAIT_REL;
      end
    endcase
  end

  assign is_digit = (code_r <= 4'd9);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      code_r    <= 4'h0;
      timer     <= 28'd0;
      entry     <= 16'h0000;
      count     <= 3'd0;
      value_out <= 16'h0000;
      tries     <= 8'h00;
      done      <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;

      if (capture) begin
        code_r <= key_code;
      end

      if (timer_run && !timer_hit) begin
        timer <= timer + 28'd1;
      end else begin
        timer <= 28'd0;
      end

      if (timer_hit) begin
        entry   <= 16'h0000;
        count   <= 3'd0;
        timeout <= 1'b1;
      end

      if (exec_en) begin
        if (is_digit) begin
          if (count < COUNT_MAX) begin
            entry <= {entry[11:0], code_r};
            count <= count + 3'd1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (code_r == KEY_BACK) begin
          if (count != 3'd0) begin
            entry <= {4'h0, entry[15:4]};
            count <= count - 3'd1;
          end
        end else if (code_r == KEY_CLEAR) begin
          entry <= 16'h0000;
          count <= 3'd0;
        end else if (code_r == KEY_ENTER) begin
          if (count != 3'd0) begin
            value_out <= entry;
            done      <= 1'b1;
            entry     <= 16'h0000;
            count     <= 3'd0;
            if (tries != 8'hFF) begin
              tries <= tries + 8'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    case (count)
      3'd0:    digit_en = 4'b0000;
      3'd1:    digit_en = 4'b0001;
      3'd2:    digit_en = 4'b0011;
      3'd3:    digit_en = 4'b0111;
      default: digit_en = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: a press-level reference model pushes the expected
// outputs for every clock edge; a negedge monitor pops and compares them.
module tb_key_entry_buffer;

  localparam int TO = 20;
  localparam int OW = 50;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_valid = 1'b0;
  logic [15:0] entry;
  logic [3:0]  digit_en;
  logic [2:0]  count;
  logic [15:0] value_out;
  logic        done;
  logic        overflow;
  logic        timeout;
  logic [7:0]  tries;

  int n_vec = 0;
  int n_err = 0;

  logic [OW-1:0] exp_q[$];

  key_entry_buffer #(.TIMEOUT_CYC(TO), .MAX_DIGITS(4)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .key_code  (key_code),
    .key_valid (key_valid),
    .entry     (entry),
    .digit_en  (digit_en),
    .count     (count),
    .value_out (value_out),
    .done      (done),
    .overflow  (overflow),
    .timeout   (timeout),
    .tries     (tries)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0]  m_buf[$];
  logic [15:0] m_value;
  int          m_tries;
  int          m_idle;
  bit          m_wait_rel;
  bit          m_have;
  logic [3:0]  m_code;
  bit          p_done, p_ovf, p_to;

  function automatic logic [15:0] m_entry();
    logic [15:0] e;
    e = 16'h0000;
    foreach (m_buf[i]) e = {e[11:0], m_buf[i]};
    return e;
  endfunction

  function automatic logic [OW-1:0] m_obs();
    logic [4:0] mask;
    mask = (5'd1 << m_buf.size()) - 5'd1;
    return {m_entry(), mask[3:0], 3'(m_buf.size()), m_value,
            p_done, p_ovf, p_to, 8'(m_tries)};
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_value    = 16'h0000;
    m_tries    = 0;
    m_idle     = 0;
    m_wait_rel = 1'b1;
    m_have     = 1'b0;
    m_code     = 4'h0;
    p_done     = 1'b0;
    p_ovf      = 1'b0;
    p_to       = 1'b0;
  endtask

  task automatic model_apply(input logic [3:0] c);
    if (c <= 4'd9) begin
      if (m_buf.size() < 4) m_buf.push_back(c);
      else p_ovf = 1'b1;
    end else if (c == 4'hA) begin
      if (m_buf.size() > 0) void'(m_buf.pop_back());
    end else if (c == 4'hB) begin
      m_buf.delete();
    end else if (c == 4'hC) begin
      if (m_buf.size() > 0) begin
        m_value = m_entry();
        p_done  = 1'b1;
        if (m_tries < 255) m_tries++;
        m_buf.delete();
      end
    end
  endtask

  task automatic model_step();
    p_done = 1'b0;
    p_ovf  = 1'b0;
    p_to   = 1'b0;
    if (m_have) begin
      m_have     = 1'b0;
      m_wait_rel = 1'b1;
      m_idle     = 0;
      model_apply(m_code);
    end else if (m_wait_rel) begin
      m_idle = 0;
      if (!key_valid) m_wait_rel = 1'b0;
    end else if (key_valid) begin
      m_have = 1'b1;
      m_code = key_code;
      m_idle = 0;
    end else if (m_buf.size() == 0) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_buf.delete();
        p_to   = 1'b1;
        m_idle = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!RSTn) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
    exp_q.push_back(m_obs());
  end

  always @(negedge RSTn) begin
    model_reset();
    exp_q.delete();
    exp_q.push_back(m_obs());
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [OW-1:0] exp_v;
    logic [OW-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {entry, digit_en, count, value_out, done, overflow, timeout, tries};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL scoreboard t=%0t {entry,en,cnt,value,done,ovf,to,tries} got %h expected %h",
                 $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap, input bit jitter);
    key_code  = code;
    key_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (jitter) key_code = 4'($urandom_range(0, 15));
    end
    key_valid = 1'b0;
    tick(gap);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // key held across reset release must not register
    RSTn      = 1'b0;
    key_code  = 4'h5;
    key_valid = 1'b1;
    tick(3);
    RSTn = 1'b1;
    tick(10);
    @(negedge clk);
    check("held_through_reset_count", 16'(count), 16'h0);
    tick(1);
    key_valid = 1'b0;
    tick(2);

    // single press, visible two edges after the press
    key_code  = 4'h5;
    key_valid = 1'b1;
    tick(1);
    @(negedge clk);
    check("press5_latency_count", 16'(count), 16'h0);
    tick(1);
    @(negedge clk);
    check("press5_entry", entry, 16'h0005);
    check("press5_count", 16'(count), 16'h1);
    check("press5_digit_en", 16'(digit_en), 16'h1);
    tick(1);
    key_valid = 1'b0;
    tick(2);

    // fill, overflow, backspace
    press(4'hB, 3, 2, 1'b0);
    for (int d = 1; d <= 5; d++) press(4'(d), 3, 2, 1'b1);
    @(negedge clk);
    check("fill_entry", entry, 16'h1234);
    check("fill_count", 16'(count), 16'h4);
    check("fill_digit_en", 16'(digit_en), 16'hF);
    press(4'hA, 3, 2, 1'b0);
    @(negedge clk);
    check("back_entry", entry, 16'h0123);
    check("back_count", 16'(count), 16'h3);

    // commit, then enter on an empty buffer
    press(4'hB, 2, 2, 1'b0);
    press(4'h4, 2, 2, 1'b0);
    press(4'h2, 2, 2, 1'b0);
    press(4'hC, 2, 2, 1'b0);
    @(negedge clk);
    check("commit_value", value_out, 16'h0042);
    check("commit_tries", 16'(tries), 16'h1);
    check("commit_entry", entry, 16'h0000);
    check("commit_count", 16'(count), 16'h0);
    press(4'hC, 2, 2, 1'b0);
    @(negedge clk);
    check("empty_enter_tries", 16'(tries), 16'h1);

    // timeout exactly TO idle cycles after returning to IDLE
    tick(1);
    press(4'h7, 1, 2, 1'b0);
    tick(TO - 1);
    @(negedge clk);
    check("pre_timeout_pulse", 16'(timeout), 16'h0);
    check("pre_timeout_count", 16'(count), 16'h1);
    tick(1);
    @(negedge clk);
    check("timeout_pulse", 16'(timeout), 16'h1);
    check("timeout_count", 16'(count), 16'h0);
    check("timeout_value_kept", value_out, 16'h0042);
    tick(2);

    // press on the expiry edge beats the timeout
    press(4'h7, 1, 2, 1'b0);
    tick(TO - 1);
    key_code  = 4'h7;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    @(negedge clk);
    check("expiry_press_no_timeout", 16'(timeout), 16'h0);
    tick(1);
    @(negedge clk);
    check("expiry_press_entry", entry, 16'h0077);
    tick(2);
    press(4'hB, 1, 2, 1'b0);

    // saturate tries
    for (int i = 0; i < 254; i++) begin
      press(4'($urandom_range(0, 9)), 1, 2, 1'b0);
      press(4'hC, 1, 2, 1'b0);
    end
    @(negedge clk);
    check("tries_255", 16'(tries), 16'h00FF);
    tick(1);
    press(4'h9, 1, 2, 1'b0);
    press(4'hC, 1, 2, 1'b0);
    @(negedge clk);
    check("tries_saturated", 16'(tries), 16'h00FF);
    check("tries_sat_value", value_out, 16'h0009);
    tick(1);

    // reset asserted while the press is in EXEC
    press(4'h1, 1, 2, 1'b0);
    key_code  = 4'h7;
    key_valid = 1'b1;
    tick(1);
    RSTn = 1'b0;
    #1;
    check("rst_exec_entry", entry, 16'h0000);
    check("rst_exec_count", 16'(count), 16'h0);
    check("rst_exec_value", value_out, 16'h0000);
    check("rst_exec_tries", 16'(tries), 16'h0);
    check("rst_exec_pulses", {13'h0, done, overflow, timeout}, 16'h0);
    tick(2);
    RSTn = 1'b1;
    tick(3);
    key_valid = 1'b0;
    tick(2);
    @(negedge clk);
    check("rst_exec_after_count", 16'(count), 16'h0);
    tick(1);

    // D, E, F change nothing
    press(4'h3, 2, 2, 1'b0);
    press(4'hD, 2, 2, 1'b0);
    press(4'hE, 2, 2, 1'b0);
    press(4'hF, 2, 2, 1'b0);
    @(negedge clk);
    check("def_entry", entry, 16'h0003);
    check("def_count", 16'(count), 16'h1);
    check("def_tries", 16'(tries), 16'h0);
    tick(1);

    // randomized presses, with occasional idle gaps around the timeout
    for (int i = 0; i < 400; i++) begin
      int r;
      int gap;
      r   = $urandom_range(0, 19);
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 6) : $urandom_range(2, 5);
      press(4'((r < 10) ? r : r - 4), $urandom_range(1, 4), gap, 1'($urandom_range(0, 1)));
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: stimulus still running at t=%0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
- Downstream consumer of the keypad decode stage (debounced one-hot to binary).
- Turns held key codes into discrete press events and maintains a 4-digit shift-entry buffer.
- Supports backspace, clear, enter and inactivity timeout; commits entered values and counts attempts.
- Feeds the 4-digit multiplexed display (entry nibbles plus blanking mask) and game/control logic (committed value, tries).

Parameters:
- TIMEOUT_CYC, 250000000, idle cycles with a non-empty buffer before auto-clear (5 s at 50 MHz); counter width 28 bits.
- MAX_DIGITS, 4, buffer depth in nibbles; fixed at 4 for this release, drives the overflow check.

Ports:
- clk  input  1  system clock, 50 MHz
- RSTn  input  1  asynchronous active-low reset
- key_code  input  4  binary code of the currently held key; valid only while key_valid=1
- key_valid  input  1  level, high while a debounced key is held; same clock domain, no synchroniser
- entry  output  16  live buffer; [3:0] is the newest digit, [15:12] the oldest
- digit_en  output  4  bit i=1 when i<count (display blanking mask)
- count  output  3  digits currently held, 0..4
- value_out  output  16  last committed entry, held until the next commit
- done  output  1  one-cycle pulse on commit
- overflow  output  1  one-cycle pulse when a digit is rejected because the buffer is full
- timeout  output  1  one-cycle pulse on auto-clear
- tries  output  8  number of commits, saturating at 8'hFF

Behaviour:
- Reset (async, RSTn=0):
  - entry, value_out, count, tries, timer all 0; digit_en=0; done, overflow, timeout = 0.
  - FSM enters WAIT_REL, so a key held across reset release is not taken as a press.
- FSM states: IDLE, EXEC, WAIT_REL.
  - IDLE: key_valid=1 at edge k -> capture key_code into code_r, go to EXEC.
  - EXEC: perform the action at edge k+1, go to WAIT_REL.
  - WAIT_REL: go to IDLE on the first edge with key_valid=0. key_code changes while held are ignored.
- Latency: buffer/output updates are visible after edge k+1. Pulses are high for exactly the cycle following edge k+1.
- Actions on code_r:
  - 0-9 (digit):
    - If count<4: entry <= {entry[11:0], code_r}, count+1.
    - Else: entry unchanged, overflow pulse.
  - A (backspace):
    - If count>0: entry <= {4'h0, entry[15:4]}, count-1.
    - Else: no-op, no pulse.
  - B (clear): entry=0, count=0. No pulse.
  - C (enter):
    - If count>0: value_out <= entry, done pulse, tries+1 (saturates at 255, stays 255), then entry=0, count=0.
    - If count=0: no-op, no pulse, tries unchanged.
  - D, E, F: ignored. The FSM still passes through EXEC and WAIT_REL.
- Timeout:
  - Timer increments each cycle in IDLE while count>0.
  - Timer clears in any other state or when count=0.
  - When the timer reaches TIMEOUT_CYC-1 in IDLE: entry=0, count=0, timer=0, timeout pulse.
  - value_out and tries are unaffected by a timeout.
- Simultaneous events: a press arriving in IDLE on the same edge the timer expires wins. Timeout is suppressed, the timer clears, and the press proceeds normally.
- digit_en is combinational from count: count 0->4'b0000, 1->0001, 2->0011, 3->0111, 4->1111.
- Reset asserted mid-EXEC: no partial update; all state returns to reset values immediately.

Test Plan:
- Reset with key_valid=1, release RSTn, keep the key held 10 cycles -> count stays 0. Drop and re-press code 5 -> entry=16'h0005, count=1, digit_en=4'b0001, visible 2 edges after the press.
- Press 1,2,3,4,5 (each held 3 cycles, released 2) -> entry=16'h1234, count=4, overflow pulses once on the 5th press. Then A -> entry=16'h0123, count=3.
- Enter digits 4,2 then C -> value_out=16'h0042, done high exactly 1 cycle, tries=1, entry=0, count=0. A second C with an empty buffer -> no done, tries=1.
- TIMEOUT_CYC=20: press 7, then idle -> timeout pulse exactly 20 idle cycles after returning to IDLE, entry=0, count=0, value_out unchanged. Press 7 on the expiry edge instead -> no timeout, entry=16'h0077.
- Preload 255 commits (C after a digit, repeated) -> tries=8'hFF. One more commit -> tries stays 8'hFF, done still pulses.
- Press 7, then assert RSTn low during the EXEC cycle -> all outputs 0 immediately. Codes D, E, F -> no change to any output.
